// File: rtl/native_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : native_mem_responder
// Brief    : Native memory-port slave backed by an internal word array, with a
//            fixed LATENCY-cycle completion pulse and per-byte write strobes.
//            Optional range check enabled by NATIVE_MEM_RANGE_CHK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module native_mem_responder #(
  parameter int BE_ADDR_W  = 32,
  parameter int BE_DATA_W  = 32,
  parameter int MEM_ADDR_W = 10,
  parameter int LATENCY    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_valid,
  input  logic [BE_ADDR_W-1:0]   mem_addr,
  input  logic [BE_DATA_W-1:0]   mem_wdata,
  input  logic [BE_DATA_W/8-1:0] mem_wstrb,
  output logic [BE_DATA_W-1:0]   mem_rdata,
`ifdef NATIVE_MEM_RANGE_CHK_EN
  output logic                   mem_err,
`endif
  output logic                   mem_ready
);

  localparam int NB         = BE_DATA_W / 8;
  localparam int BE_BYTE_W  = $clog2(NB);
  localparam int ADDR_HI    = BE_BYTE_W + MEM_ADDR_W;
  localparam int MEM_DEPTH  = 1 << MEM_ADDR_W;
  localparam logic [3:0] C_CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [3:0]              r_cnt;
  logic [3:0]              w_cnt_nxt;
  logic                    w_capture;
  logic                    w_commit;
  logic [BE_ADDR_W-1:0]    r_addr;
  logic [BE_DATA_W-1:0]    r_wdata;
  logic [NB-1:0]           r_wstrb;
  logic [MEM_ADDR_W-1:0]   w_idx;
  logic                    w_is_wr;
  logic                    w_oor;
  logic                    w_unused_addr;
  logic [BE_DATA_W-1:0]    r_mem [MEM_DEPTH];

  assign w_idx         = r_addr[BE_BYTE_W +: MEM_ADDR_W];
  assign w_is_wr       = |r_wstrb;
  assign w_unused_addr = ^r_addr;

`ifdef NATIVE_MEM_RANGE_CHK_EN
  if (BE_ADDR_W > ADDR_HI) begin : g_range_chk
    assign w_oor = |r_addr[BE_ADDR_W-1:ADDR_HI];
  end else begin : g_no_upper_bits
    assign w_oor = 1'b0;
  end
`else
  // Upper address bits alias onto the array.
  assign w_oor = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (mem_valid) begin
          w_capture   = 1'b1;
          w_cnt_nxt   = C_CNT_LOAD;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        // Completion ignores mem_valid so a dropped request still finishes.
        if (r_cnt == 4'd0) begin
          w_commit    = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
`ifdef NATIVE_MEM_RANGE_CHK_EN
      mem_err   <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      mem_ready <= w_commit;
      if (w_capture) begin
        r_addr  <= mem_addr;
        r_wdata <= mem_wdata;
        r_wstrb <= mem_wstrb;
      end
      if (w_commit && !w_is_wr) begin
        mem_rdata <= w_oor ? '0 : r_mem[w_idx];
      end
`ifdef NATIVE_MEM_RANGE_CHK_EN
      mem_err   <= w_commit && w_oor;
`endif
    end
  end

  // Array is deliberately outside reset; reset forces IDLE so no write commits.
  always_ff @(posedge clk) begin
    if (w_commit && w_is_wr && !w_oor) begin
      for (int i = 0; i < NB; i++) begin
        if (r_wstrb[i]) begin
          r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/native_mem_responder.md
NATIVE_MEM_RESPONDER -- requirements
Module: native_mem_responder

Interface
REQ-001 SHALL have parameter BE_ADDR_W, default 32, byte-address width of the native memory port.
REQ-002 SHALL have parameter BE_DATA_W, default 32, data width; multiple of 8, at least 8.
REQ-003 SHALL have parameter MEM_ADDR_W, default 10, log2 of the word depth of the internal array.
REQ-004 SHALL have parameter LATENCY, default 2, cycles from request sample to mem_ready; legal range 1..15.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-007 SHALL have port mem_valid, input, 1, request valid, held by the initiator until mem_ready.
REQ-008 SHALL have port mem_addr, input, BE_ADDR_W, byte address.
REQ-009 SHALL have port mem_wdata, input, BE_DATA_W, write data.
REQ-010 SHALL have port mem_wstrb, input, BE_DATA_W/8, byte strobes; all-zero means read.
REQ-011 SHALL have port mem_rdata, output, BE_DATA_W, read data, registered.
REQ-012 SHALL have port mem_ready, output, 1, one-cycle completion pulse, registered.
REQ-013 SHALL have port mem_err, output, 1, out-of-range pulse; present only with NATIVE_MEM_RANGE_CHK_EN.

Function
REQ-014 SHALL index words as mem_addr[BE_BYTE_W +: MEM_ADDR_W], where BE_BYTE_W = log2(BE_DATA_W/8); the low byte-offset bits are ignored.
REQ-015 SHALL implement an FSM with states IDLE and WAIT only.
REQ-016 In IDLE with mem_valid=1 at edge k, the FSM SHALL capture addr, wdata and wstrb, load the counter with LATENCY-1, and enter WAIT.
REQ-017 In WAIT, the counter SHALL decrement each edge; at the edge where it equals 0, the access SHALL be performed, mem_ready set to 1, and the FSM SHALL return to IDLE.
REQ-018 mem_ready SHALL be high only during the cycle between edges k+LATENCY and k+LATENCY+1, and low otherwise.
REQ-019 For a write, only the bytes with wstrb[i]=1 SHALL be updated at edge k+LATENCY; unstrobed bytes SHALL keep their value.
REQ-020 For a read, mem_rdata SHALL present the addressed word during the mem_ready cycle and hold it until the next read completes.
REQ-021 For a write, mem_rdata SHALL hold its previous value.
REQ-022 The next request SHALL be sampled no earlier than edge k+LATENCY+1; mem_valid seen during the mem_ready cycle SHALL NOT start a transaction.
REQ-023 Back-to-back requests SHALL complete at one transaction per LATENCY+1 cycles.
REQ-024 Captured fields SHALL be used for the access; changes to mem_addr, mem_wdata or mem_wstrb during WAIT SHALL be ignored.
REQ-025 If mem_valid drops during WAIT (protocol violation), the transaction SHALL still complete and pulse mem_ready.
REQ-026 Write-after-read and read-after-write to the same word SHALL return the updated data on the following read.

Reset
REQ-027 While reset=0: state SHALL be IDLE, counter 0, mem_ready 0, mem_rdata 0, mem_err 0.
REQ-028 Reset asserted mid-transaction SHALL abort it; an uncommitted write SHALL NOT modify the array.
REQ-029 The array contents SHALL NOT be cleared by reset.

Configuration
REQ-030 With NATIVE_MEM_RANGE_CHK_EN defined, an out-of-range request (any captured address bit at or above BE_BYTE_W+MEM_ADDR_W is nonzero) SHALL complete with normal latency, write nothing, return mem_rdata=0, and pulse mem_err together with mem_ready.
REQ-031 Without NATIVE_MEM_RANGE_CHK_EN, the upper address bits SHALL be ignored (aliasing), and port mem_err SHALL NOT exist.

Verification
REQ-032 Reset release, then write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF at LATENCY=2 -> mem_ready pulses 2 cycles after the sample edge, high for exactly 1 cycle.
REQ-033 Read addr 0x10 after REQ-032 -> mem_rdata=0xDEADBEEF in the mem_ready cycle and held afterwards.
REQ-034 Write addr 0x10, wdata 0x11223344, wstrb 0x5, then read -> 0xDE22BE44.
REQ-035 mem_valid held high across 4 reads at LATENCY=1 -> exactly 4 mem_ready pulses, 2 cycles apart, with no duplicate access.
REQ-036 Reset driven to 0 one cycle after a write to 0x20 is sampled -> mem_ready stays 0, and a subsequent read of 0x20 returns the old value.
REQ-037 With NATIVE_MEM_RANGE_CHK_EN, MEM_ADDR_W=10, write to 0x1000 -> mem_err and mem_ready pulse together, and a read of 0x0 is unchanged.
